// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - state encoding and address-width helper for the FIR sequencer
package fir_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t LOAD  = 3'd1;
    localparam state_t GET   = 3'd2;
    localparam state_t START = 3'd3;
    localparam state_t WAIT  = 3'd4;
    localparam state_t PUSH  = 3'd5;
    localparam state_t FIN   = 3'd6;

    function automatic int tap_addr_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/fir_seq_outbuf.sv
// rtl/fir_seq_outbuf.sv - one-entry result register between the engine and the result stream
module fir_seq_outbuf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  clear,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - tap loader and sample/result sequencer for the single-sample FIR engine
// Optional engine watchdog enabled by defining FIR_SEQ_TIMEOUT_EN.
module fir_seq_ctrl
    import fir_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int TAP_NUM     = 16,
    parameter int LEN_WIDTH   = 16,
`ifdef FIR_SEQ_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 64,
`endif
    localparam int TAP_AW     = tap_addr_width(TAP_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_go,
    input  logic                  cfg_reload,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  tap_valid,
    output logic                  tap_ready,
    input  logic [DATA_WIDTH-1:0] tap_data,
    input  logic                  ss_valid,
    output logic                  ss_ready,
    input  logic [DATA_WIDTH-1:0] ss_data,
    output logic                  sm_valid,
    input  logic                  sm_ready,
    output logic [DATA_WIDTH-1:0] sm_data,
    output logic                  sm_last,
    output logic                  fir_tap_we,
    output logic [TAP_AW-1:0]     fir_tap_addr,
    output logic [DATA_WIDTH-1:0] fir_tap_data,
    output logic                  fir_start,
    output logic [DATA_WIDTH-1:0] fir_x_in,
    input  logic [DATA_WIDTH-1:0] fir_y_out,
    input  logic                  fir_done,
    output logic                  busy,
    output logic                  job_done,
    output logic                  err
);

    state_t                state, state_nxt;
    logic [TAP_AW-1:0]     tap_idx;
    logic [LEN_WIDTH-1:0]  count, count_inc, len_r;
    logic [DATA_WIDTH-1:0] x_reg;
    logic                  go_acc, tap_hs, ss_hs, sm_hs, tap_last, wd_expire;

    assign go_acc    = (state == IDLE) && cfg_go;
    assign tap_hs    = (state == LOAD) && tap_valid;
    assign ss_hs     = (state == GET) && ss_valid;
    assign sm_hs     = sm_valid && sm_ready;
    assign tap_last  = tap_idx == TAP_AW'(TAP_NUM - 1);
    assign count_inc = count + 1'b1;

`ifdef FIR_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    logic [WD_W-1:0] wd_cnt;
    logic            err_r;

    assign wd_expire = (state == WAIT) && !fir_done && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign err       = err_r;

    // Counter only runs while an engine result is outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err_r  <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
            if (go_acc)
                err_r <= 1'b0;
            else if (wd_expire)
                err_r <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_idx <= '0;
            count   <= '0;
            len_r   <= '0;
            x_reg   <= '0;
        end else begin
            if (go_acc) begin
                len_r <= cfg_len;
                count <= '0;
            end
            if (tap_hs)
                tap_idx <= tap_last ? '0 : tap_idx + 1'b1;
            if (ss_hs)
                x_reg <= ss_data;
            if ((state == PUSH) && sm_hs)
                count <= count_inc;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cfg_go) state_nxt = cfg_reload ? LOAD : ((cfg_len == '0) ? FIN : GET);
            LOAD:  if (tap_hs && tap_last) state_nxt = (len_r == '0) ? FIN : GET;
            GET:   if (ss_hs) state_nxt = START;
            START: state_nxt = WAIT;
            WAIT:  if (fir_done) state_nxt = PUSH;
                   else if (wd_expire) state_nxt = FIN;
            PUSH:  if (sm_hs) state_nxt = (count_inc == len_r) ? FIN : GET;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tap_ready    = (state == LOAD);
        fir_tap_we   = tap_hs;
        fir_tap_addr = (state == LOAD) ? tap_idx : '0;
        fir_tap_data = (state == LOAD) ? tap_data : '0;
        ss_ready     = (state == GET);
        fir_start    = (state == START);
        fir_x_in     = x_reg;
        busy         = (state != IDLE) && (state != FIN);
        job_done     = (state == FIN);
    end

    fir_seq_outbuf #(.DATA_WIDTH(DATA_WIDTH)) u_outbuf (
        .clk       (clk),
        .rst       (rst),
        .load      ((state == WAIT) && fir_done),
        .load_data (fir_y_out),
        .load_last (count == len_r - 1'b1),
        .clear     (sm_hs),
        .valid     (sm_valid),
        .data      (sm_data),
        .last      (sm_last)
    );

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - randomized scoreboard bench for fir_seq_ctrl with a behavioural engine model
module tb_fir_seq_ctrl;

    logic        clk, rst;
    logic        cfg_go, cfg_reload;
    logic [15:0] cfg_len;
    logic        tap_valid, tap_ready, ss_valid, ss_ready;
    logic [31:0] tap_data, ss_data;
    logic        sm_valid, sm_ready, sm_last;
    logic [31:0] sm_data;
    logic        fir_tap_we, fir_start, fir_done;
    logic [3:0]  fir_tap_addr;
    logic [31:0] fir_tap_data, fir_x_in, fir_y_out;
    logic        busy, job_done, err;

    typedef struct {
        logic [31:0] y;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_taps [16];
    logic [31:0] eng_taps [16];
    int          n_cmp, n_bad;
    int          n_tapwe, n_start, n_jobdone, n_ssrdy, n_sm;
    bit          eng_mute, sm_hold;

    fir_seq_ctrl dut (
        .clk(clk), .rst(rst), .cfg_go(cfg_go), .cfg_reload(cfg_reload), .cfg_len(cfg_len),
        .tap_valid(tap_valid), .tap_ready(tap_ready), .tap_data(tap_data),
        .ss_valid(ss_valid), .ss_ready(ss_ready), .ss_data(ss_data),
        .sm_valid(sm_valid), .sm_ready(sm_ready), .sm_data(sm_data), .sm_last(sm_last),
        .fir_tap_we(fir_tap_we), .fir_tap_addr(fir_tap_addr), .fir_tap_data(fir_tap_data),
        .fir_start(fir_start), .fir_x_in(fir_x_in), .fir_y_out(fir_y_out), .fir_done(fir_done),
        .busy(busy), .job_done(job_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine result: sum of tap[i] * (x + i), truncated to 32 bits.
    function automatic logic [31:0] fir_ref(input logic [31:0] t [16], input logic [31:0] x);
        logic [31:0] acc;
        acc = 32'd0;
        for (int i = 0; i < 16; i++) acc += t[i] * (x + 32'(i));
        return acc;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    always @(negedge clk) begin
        if (fir_tap_we) eng_taps[fir_tap_addr] = fir_tap_data;
    end

    initial begin
        logic [31:0] y;
        fir_done  = 1'b0;
        fir_y_out = 32'd0;
        forever begin
            @(negedge clk);
            if (fir_start && !eng_mute) begin
                y = fir_ref(eng_taps, fir_x_in);
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                fir_done  = 1'b1;
                fir_y_out = y;
                @(posedge clk);
                #1;
                fir_done  = 1'b0;
                fir_y_out = $urandom;
            end
        end
    end

    initial begin
        sm_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sm_ready = sm_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (fir_tap_we) n_tapwe++;
        if (fir_start)  n_start++;
        if (job_done)   n_jobdone++;
        if (ss_ready)   n_ssrdy++;
        if (sm_valid && sm_ready) begin
            n_sm++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got 0x%0h want none", sm_data);
            end else begin
                e = exp_q.pop_front();
                chk("sm_data", sm_data, e.y);
                chk("sm_last", sm_last, e.last);
            end
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_tap_ready"}, tap_ready, 0);
        chk({tag, "_ss_ready"}, ss_ready, 0);
        chk({tag, "_sm_valid"}, sm_valid, 0);
        chk({tag, "_sm_data"}, sm_data, 0);
        chk({tag, "_sm_last"}, sm_last, 0);
        chk({tag, "_fir_tap_we"}, fir_tap_we, 0);
        chk({tag, "_fir_tap_addr"}, fir_tap_addr, 0);
        chk({tag, "_fir_tap_data"}, fir_tap_data, 0);
        chk({tag, "_fir_start"}, fir_start, 0);
        chk({tag, "_fir_x_in"}, fir_x_in, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_job_done"}, job_done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input bit is_tap, input logic [31:0] d);
        bit acc;
        int c;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if (is_tap) begin tap_valid = 1'b1; tap_data = d; end
        else        begin ss_valid  = 1'b1; ss_data  = d; end
        acc = 1'b0;
        c   = 0;
        while (!acc && c < 300) begin
            @(negedge clk);
            acc = is_tap ? tap_ready : ss_ready;
            @(posedge clk);
            #1;
            c++;
        end
        tap_valid = 1'b0;
        ss_valid  = 1'b0;
        tap_data  = $urandom;
        ss_data   = $urandom;
        if (!acc) fail_now(is_tap ? "tap_handshake" : "ss_handshake");
    endtask

    task automatic wait_job();
        int c;
        c = 0;
        while (n_jobdone == 0 && c < 3000) begin @(posedge clk); #1; c++; end
        if (n_jobdone == 0) fail_now("job_done_wait");
    endtask

    task automatic pulse_go(input bit reload, input int len);
        cfg_go     = 1'b1;
        cfg_reload = reload;
        cfg_len    = 16'(len);
        @(posedge clk);
        #1;
        cfg_go     = 1'b0;
        cfg_reload = 1'($urandom);
        cfg_len    = 16'($urandom);
    endtask

    task automatic run_job(input bit reload, input int len, input bit seq, input bit stall);
        logic [31:0] v;
        exp_t        e;
        int          c;
        n_tapwe = 0; n_start = 0; n_jobdone = 0; n_ssrdy = 0; n_sm = 0;
        sm_hold = stall;
        pulse_go(reload, len);
        if (reload || len != 0) begin
            @(negedge clk);
            chk("busy_after_go", busy, 1);
            @(posedge clk);
            #1;
        end
        if (reload) begin
            for (int i = 0; i < 16; i++) begin
                v = seq ? 32'(i + 1) : 32'($urandom_range(0, 255));
                ref_taps[i] = v;
                send_beat(1'b1, v);
            end
            if (len == 0) begin
                @(negedge clk);
                chk("job_done_after_last_tap", job_done, 1);
                @(posedge clk);
                #1;
            end
        end
        for (int s = 0; s < len; s++) begin
            v = seq ? 32'(s + 1) : 32'($urandom_range(0, 1000));
            e.y    = fir_ref(ref_taps, v);
            e.last = (s == len - 1);
            exp_q.push_back(e);
            send_beat(1'b0, v);
            if (stall && s == 0) begin
                c = 0;
                while (!sm_valid && c < 100) begin @(negedge clk); c++; end
                if (!sm_valid) fail_now("stall_sm_valid");
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk("stall_sm_valid", sm_valid, 1);
                    chk("stall_sm_data", sm_data, exp_q[0].y);
                    chk("stall_sm_last", sm_last, exp_q[0].last);
                    chk("stall_ss_ready", ss_ready, 0);
                    chk("stall_starts", n_start, 1);
                end
                @(posedge clk);
                #1;
                sm_hold = 1'b0;
            end
        end
        wait_job();
        @(negedge clk);
        chk("busy_after_job", busy, 0);
        chk("tap_writes", n_tapwe, reload ? 16 : 0);
        chk("engine_starts", n_start, len);
        chk("results", n_sm, len);
        chk("queue_empty", exp_q.size(), 0);
        chk("job_done_pulses", n_jobdone, 1);
        if (len == 0) chk("ss_ready_cycles", n_ssrdy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c, d;
        n_cmp = 0; n_bad = 0;
        n_tapwe = 0; n_start = 0; n_jobdone = 0; n_ssrdy = 0; n_sm = 0;
        eng_mute = 1'b0; sm_hold = 1'b0;
        rst = 1'b1; cfg_go = 1'b0; cfg_reload = 1'b0; cfg_len = 16'd0;
        tap_valid = 1'b0; tap_data = 32'd0; ss_valid = 1'b0; ss_data = 32'd0;
        for (int i = 0; i < 16; i++) begin ref_taps[i] = 32'd0; eng_taps[i] = 32'd0; end
        repeat (3) @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_job(1'b1, 4, 1'b1, 1'b0);
        run_job(1'b0, 2, 1'b1, 1'b0);
        run_job(1'b0, 2, 1'b0, 1'b1);
        run_job(1'b1, 0, 1'b0, 1'b0);

        // Ignored go while busy, then reset with a result outstanding.
        eng_mute = 1'b1;
        n_start  = 0;
        pulse_go(1'b0, 3);
        send_beat(1'b0, 32'd5);
        c = 0;
        while (n_start == 0 && c < 100) begin @(posedge clk); #1; c++; end
        if (n_start == 0) fail_now("mid_job_start");
        pulse_go(1'b1, 5);
        @(negedge clk);
        chk("go_while_busy_tap_ready", tap_ready, 0);
        chk("go_while_busy_busy", busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_quiet("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        eng_mute = 1'b0;
        exp_q.delete();
        run_job(1'b0, 3, 1'b0, 1'b0);

        for (int j = 0; j < 6; j++)
            run_job(1'($urandom_range(0, 1)), $urandom_range(1, 6), 1'b0, 1'b0);

`ifdef FIR_SEQ_TIMEOUT_EN
        eng_mute = 1'b1;
        n_sm = 0; n_jobdone = 0;
        pulse_go(1'b0, 2);
        send_beat(1'b0, 32'd7);
        @(negedge clk);
        c = 0;
        while (!fir_start && c < 100) begin @(negedge clk); c++; end
        d = 0;
        do begin @(negedge clk); d++; end while (!job_done && d < 300);
        chk("timeout_cycles", d, 65);
        chk("timeout_err", err, 1);
        chk("timeout_no_result", n_sm, 0);
        @(posedge clk);
        #1;
        eng_mute = 1'b0;
        run_job(1'b0, 1, 1'b0, 1'b0);
        @(negedge clk);
        chk("err_cleared", err, 0);
        @(posedge clk);
        #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
